imem_boot_loader: RTL

- Upstream stage of the single-cycle MIPS core.
- Receives a program image as a byte stream using a valid/ready handshake.
- Assembles the bytes into 32-bit big-endian words and writes them into the instruction memory, one word per address.
- Holds the core in reset until the image is fully loaded and its checksum verifies. On success it releases the core, and the PC starts at word 0.

---
 rtl/imem_boot_loader_if.sv | 30 +++
 rtl/imem_boot_loader.sv | 137 +++++++++++++
 2 files changed

// File: rtl/imem_boot_loader_if.sv
// Byte-stream input and instruction-memory write bus of the boot loader.
// The source drives start/byte_in/byte_valid and the loader drives the rest.
interface imem_boot_loader_if #(
   parameter int ADDR_W = 8
);
   logic              start;
   logic [7:0]        byte_in;
   logic              byte_valid;
   logic              byte_ready;
   logic              imem_we;
   logic [ADDR_W-1:0] imem_addr;
   logic [31:0]       imem_wdata;
   logic              core_rst;
   logic              busy;
   logic              done;
   logic              error;
   logic [ADDR_W:0]   words_loaded;

   modport master (
      output start, byte_in, byte_valid,
      input  byte_ready, imem_we, imem_addr, imem_wdata,
      input  core_rst, busy, done, error, words_loaded
   );

   modport slave (
      input  start, byte_in, byte_valid,
      output byte_ready, imem_we, imem_addr, imem_wdata,
      output core_rst, busy, done, error, words_loaded
   );
endinterface

// File: rtl/imem_boot_loader.sv
// Loads a length-prefixed, XOR-checksummed byte image into imem as big-endian words; 4th byte -> imem_we next cycle.
// byte_ready is a pure function of state (low in WRITE/IDLE/DONE/ERROR); stalls on byte_valid hold all state.
module imem_boot_loader #(
   parameter int ADDR_W    = 8,
   parameter int MAX_WORDS = 256
) (
   input  logic                clk,
   input  logic                rst,
   imem_boot_loader_if.slave   bus
);
   typedef enum logic [2:0] {
      S_IDLE, S_LEN_HI, S_LEN_LO, S_DATA, S_WRITE, S_CSUM, S_DONE, S_ERROR
   } state_t;

   state_t            r_state;
   logic              r_byte_ready;
   logic              r_imem_we;
   logic [ADDR_W-1:0] r_imem_addr;
   logic [31:0]       r_imem_wdata;
   logic              r_core_rst;
   logic              r_busy;
   logic              r_done;
   logic              r_error;
   logic [ADDR_W:0]   r_words_loaded;
   logic [15:0]       r_len;
   logic [23:0]       r_word;
   logic [7:0]        r_xor;
   logic [1:0]        r_idx;

   logic              w_xfer;
   logic [15:0]       w_len;
   logic [ADDR_W:0]   w_wl_inc;

   assign w_xfer   = bus.byte_valid && r_byte_ready;
   assign w_len    = {r_len[15:8], bus.byte_in};
   assign w_wl_inc = r_words_loaded + (ADDR_W+1)'(1);

   // Outputs are registered: each transition also loads the outputs of the state it enters.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state        <= S_IDLE;
         r_byte_ready   <= 1'b0;
         r_imem_we      <= 1'b0;
         r_imem_addr    <= '0;
         r_imem_wdata   <= '0;
         r_core_rst     <= 1'b1;
         r_busy         <= 1'b0;
         r_done         <= 1'b0;
         r_error        <= 1'b0;
         r_words_loaded <= '0;
         r_len          <= '0;
         r_word         <= '0;
         r_xor          <= '0;
         r_idx          <= '0;
      end else begin
         r_imem_we <= 1'b0;
         case (r_state)
            S_IDLE, S_DONE, S_ERROR: begin
               if (bus.start) begin
                  r_state        <= S_LEN_HI;
                  r_byte_ready   <= 1'b1;
                  r_busy         <= 1'b1;
                  r_core_rst     <= 1'b1;
                  r_done         <= 1'b0;
                  r_error        <= 1'b0;
                  r_words_loaded <= '0;
                  r_idx          <= '0;
                  r_xor          <= '0;
               end
            end
            S_LEN_HI: begin
               if (w_xfer) begin
                  r_len[15:8] <= bus.byte_in;
                  r_state     <= S_LEN_LO;
               end
            end
            S_LEN_LO: begin
               if (w_xfer) begin
                  r_len[7:0] <= bus.byte_in;
                  if (w_len == 16'd0 || w_len > 16'(MAX_WORDS)) begin
                     r_state      <= S_ERROR;
                     r_byte_ready <= 1'b0;
                     r_busy       <= 1'b0;
                     r_error      <= 1'b1;
                  end else begin
                     r_state <= S_DATA;
                  end
               end
            end
            S_DATA: begin
               if (w_xfer) begin
                  r_word <= {r_word[15:0], bus.byte_in};
                  r_xor  <= r_xor ^ bus.byte_in;
                  r_idx  <= r_idx + 2'd1;
                  if (r_idx == 2'd3) begin
                     r_state      <= S_WRITE;
                     r_byte_ready <= 1'b0;
                     r_imem_we    <= 1'b1;
                     r_imem_addr  <= r_words_loaded[ADDR_W-1:0];
                     r_imem_wdata <= {r_word, bus.byte_in};
                  end
               end
            end
            S_WRITE: begin
               r_words_loaded <= w_wl_inc;
               r_byte_ready   <= 1'b1;
               r_state        <= (16'(w_wl_inc) == r_len) ? S_CSUM : S_DATA;
            end
            S_CSUM: begin
               if (w_xfer) begin
                  r_byte_ready <= 1'b0;
                  r_busy       <= 1'b0;
                  if (bus.byte_in == r_xor) begin
                     r_state    <= S_DONE;
                     r_done     <= 1'b1;
                     r_core_rst <= 1'b0;
                  end else begin
                     r_state <= S_ERROR;
                     r_error <= 1'b1;
                  end
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign bus.byte_ready   = r_byte_ready;
   assign bus.imem_we      = r_imem_we;
   assign bus.imem_addr    = r_imem_addr;
   assign bus.imem_wdata   = r_imem_wdata;
   assign bus.core_rst     = r_core_rst;
   assign bus.busy         = r_busy;
   assign bus.done         = r_done;
   assign bus.error        = r_error;
   assign bus.words_loaded = r_words_loaded;
endmodule
